// File: rtl/mbc1_cart_responder.sv
// MBC1 cartridge responder: synchronises CPU bus strobes, keeps the bank registers and turns reads into timed ROM/SRAM fetches.
// Read data drives the bus MEM_LAT+1 clocks after the detected read edge; writes commit once wr_n returns high.
module mbc1_cart_responder #(
   parameter int ROM_BANKS = 64,
   parameter int RAM_BANKS = 4,
   parameter int MEM_LAT   = 2
) (
   input  logic        pllClk,
   input  logic        reset_n,
   input  logic [15:0] add,
   input  logic [7:0]  data_in,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        cs_n,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [20:0] rom_addr,
   output logic        rom_rd,
   input  logic [7:0]  rom_data,
   output logic [14:0] ram_addr,
   output logic        ram_rd,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_data
);

   localparam logic [6:0]  ROM_MASK = 7'(ROM_BANKS - 1);
   localparam logic [14:0] RAM_MASK = (RAM_BANKS == 4) ? 15'h7fff : 15'h1fff;
   localparam bit          HAS_RAM  = (RAM_BANKS > 0);
   localparam logic [2:0]  LAT      = 3'(MEM_LAT);

   typedef enum logic [1:0] {IDLE, FETCH, DRIVE} state_t;
   typedef enum logic [1:0] {SRC_ROM, SRC_RAM, SRC_FLOAT} src_t;

   logic [15:0] add_s1, add_s2, wr_add;
   logic [7:0]  din_s1, din_s2, wr_dat;
   logic        rd_n_s1, rd_n_s2, wr_n_s1, wr_n_s2, cs_n_s1, cs_n_s2, wr_cs_n;
   logic        clash;
   logic        ram_en, mode;
   logic [4:0]  bank1;
   logic [1:0]  bank2;
   state_t      state;
   src_t        src;
   logic [2:0]  cnt;

   logic [4:0]  bank1_eff;
   logic [1:0]  ram_hi;
   logic [6:0]  bank_lo, bank_hi;
   logic        rd_det, wr_commit;

   assign bank1_eff = (bank1 == 5'd0) ? 5'd1 : bank1;
   assign ram_hi    = mode ? bank2 : 2'b00;
   assign bank_lo   = {ram_hi, 5'b0} & ROM_MASK;
   assign bank_hi   = {bank2, bank1_eff} & ROM_MASK;
   // A read and a write strobed together poison both until the bus is fully released.
   assign rd_det    = (state == IDLE) && !rd_n_s1 && rd_n_s2 && wr_n_s1 && !clash;
   assign wr_commit = (state == IDLE) && wr_n_s1 && !wr_n_s2 && !clash;

   always_ff @(posedge pllClk) begin
      if (!reset_n) begin
         add_s1 <= '0;  add_s2 <= '0;  din_s1 <= '0;  din_s2 <= '0;
         rd_n_s1 <= 1'b1; rd_n_s2 <= 1'b1; wr_n_s1 <= 1'b1; wr_n_s2 <= 1'b1;
         cs_n_s1 <= 1'b1; cs_n_s2 <= 1'b1;
         wr_add <= '0;  wr_dat <= '0;  wr_cs_n <= 1'b1;  clash <= 1'b0;
         ram_en <= 1'b0; bank1 <= '0; bank2 <= '0; mode <= 1'b0;
         state <= IDLE; src <= SRC_ROM; cnt <= '0;
         data_out <= 8'hff; data_oe <= 1'b0;
         rom_rd <= 1'b0; ram_rd <= 1'b0; ram_we <= 1'b0;
         rom_addr <= '0; ram_addr <= '0; ram_wdata <= '0;
      end else begin
         add_s1  <= add;     add_s2  <= add_s1;
         din_s1  <= data_in; din_s2  <= din_s1;
         rd_n_s1 <= rd_n;    rd_n_s2 <= rd_n_s1;
         wr_n_s1 <= wr_n;    wr_n_s2 <= wr_n_s1;
         cs_n_s1 <= cs_n;    cs_n_s2 <= cs_n_s1;
         rom_rd  <= 1'b0;
         ram_rd  <= 1'b0;
         ram_we  <= 1'b0;

         if (!wr_n_s2) begin
            wr_add  <= add_s2;
            wr_dat  <= din_s2;
            wr_cs_n <= cs_n_s2;
         end

         if (!rd_n_s1 && !wr_n_s1)
            clash <= 1'b1;
         else if (rd_n_s1 && rd_n_s2 && wr_n_s1 && wr_n_s2)
            clash <= 1'b0;

         if (wr_commit) begin
            case (wr_add[15:13])
               3'b000: ram_en <= (wr_dat[3:0] == 4'ha);
               3'b001: bank1  <= wr_dat[4:0];
               3'b010: bank2  <= wr_dat[1:0];
               3'b011: mode   <= wr_dat[0];
               3'b101: if (HAS_RAM && ram_en && !wr_cs_n) begin
                  ram_we    <= 1'b1;
                  ram_addr  <= {ram_hi, wr_add[12:0]} & RAM_MASK;
                  ram_wdata <= wr_dat;
               end
               default: ;
            endcase
         end

         case (state)
            IDLE: if (rd_det) begin
               if (!add_s2[15]) begin
                  rom_rd   <= 1'b1;
                  rom_addr <= {add_s2[14] ? bank_hi : bank_lo, add_s2[13:0]};
                  src      <= SRC_ROM;
                  cnt      <= LAT;
                  state    <= FETCH;
               end else if (add_s2[15:13] == 3'b101 && !cs_n_s2) begin
                  if (HAS_RAM && ram_en) begin
                     ram_rd   <= 1'b1;
                     ram_addr <= {ram_hi, add_s2[12:0]} & RAM_MASK;
                     src      <= SRC_RAM;
                     cnt      <= LAT;
                  end else begin
                     // Disabled RAM answers with a floating bus one clock after the read edge.
                     src <= SRC_FLOAT;
                     cnt <= 3'd0;
                  end
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (rd_n_s1) begin
                  state <= IDLE;
               end else if (cnt == 3'd0) begin
                  case (src)
                     SRC_ROM: data_out <= rom_data;
                     SRC_RAM: data_out <= ram_data;
                     default: data_out <= 8'hff;
                  endcase
                  data_oe <= 1'b1;
                  state   <= DRIVE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            DRIVE: if (rd_n_s1) begin
               data_oe  <= 1'b0;
               data_out <= 8'hff;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbc1_cart_responder.sv
// Drives two responder builds (64 ROM banks / 4 RAM banks / latency 2 and 128 / 1 / 3) with one shared CPU bus.
// A bank-arithmetic model predicts every memory request, drive timing and returned byte.
module tb_mbc1_cart_responder;

   localparam int LAT0 = 2;
   localparam int LAT1 = 3;

   logic        pllClk = 1'b0;
   logic        reset_n;
   logic [15:0] add;
   logic [7:0]  data_in;
   logic        rd_n, wr_n, cs_n;

   logic [7:0]  data_out  [2];
   logic        data_oe   [2];
   logic [20:0] rom_addr  [2];
   logic        rom_rd    [2];
   logic [7:0]  rom_data  [2];
   logic [14:0] ram_addr  [2];
   logic        ram_rd    [2];
   logic        ram_we    [2];
   logic [7:0]  ram_wdata [2];
   logic [7:0]  ram_data  [2];

   int checks   = 0;
   int failures = 0;

   always #5 pllClk = ~pllClk;

   mbc1_cart_responder #(.ROM_BANKS(64), .RAM_BANKS(4), .MEM_LAT(LAT0)) dut0 (
      .pllClk(pllClk), .reset_n(reset_n), .add(add), .data_in(data_in),
      .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n),
      .data_out(data_out[0]), .data_oe(data_oe[0]),
      .rom_addr(rom_addr[0]), .rom_rd(rom_rd[0]), .rom_data(rom_data[0]),
      .ram_addr(ram_addr[0]), .ram_rd(ram_rd[0]), .ram_we(ram_we[0]),
      .ram_wdata(ram_wdata[0]), .ram_data(ram_data[0]));

   mbc1_cart_responder #(.ROM_BANKS(128), .RAM_BANKS(1), .MEM_LAT(LAT1)) dut1 (
      .pllClk(pllClk), .reset_n(reset_n), .add(add), .data_in(data_in),
      .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n),
      .data_out(data_out[1]), .data_oe(data_oe[1]),
      .rom_addr(rom_addr[1]), .rom_rd(rom_rd[1]), .rom_data(rom_data[1]),
      .ram_addr(ram_addr[1]), .ram_rd(ram_rd[1]), .ram_we(ram_we[1]),
      .ram_wdata(ram_wdata[1]), .ram_data(ram_data[1]));

   function automatic int lat_of(input int d);  return (d == 0) ? LAT0 : LAT1; endfunction
   function automatic int rb_of(input int d);   return (d == 0) ? 64 : 128;    endfunction
   function automatic int ramb_of(input int d); return (d == 0) ? 4 : 1;       endfunction

   function automatic logic [7:0] rom_byte(input logic [20:0] x);
      return x[7:0] ^ x[15:8] ^ {x[20:16], 3'b101};
   endfunction

   function automatic logic [7:0] sram_init(input int i);
      return 8'(i * 7 + 3) ^ 8'(i >> 8);
   endfunction

   // Memory stand-ins: data appears exactly MEM_LAT clocks after the request, noise otherwise.
   logic [7:0] rom_pipe [2][8];
   logic [7:0] ram_pipe [2][8];
   logic [7:0] sram_mem [2][32768];
   bit         mem_ready = 1'b0;

   always @(posedge pllClk) begin
      if (!mem_ready) begin
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32768; i++) sram_mem[d][i] = sram_init(i);
         mem_ready = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
         if (ram_we[d]) sram_mem[d][ram_addr[d]] = ram_wdata[d];
         for (int k = 7; k > 0; k--) begin
            rom_pipe[d][k] <= rom_pipe[d][k-1];
            ram_pipe[d][k] <= ram_pipe[d][k-1];
         end
         rom_pipe[d][0] <= rom_rd[d] ? rom_byte(rom_addr[d]) : 8'($urandom);
         ram_pipe[d][0] <= ram_rd[d] ? sram_mem[d][ram_addr[d]] : 8'($urandom);
      end
   end

   assign rom_data[0] = rom_pipe[0][LAT0-1];
   assign rom_data[1] = rom_pipe[1][LAT1-1];
   assign ram_data[0] = ram_pipe[0][LAT0-1];
   assign ram_data[1] = ram_pipe[1][LAT1-1];

   // Reference model: MBC1 register file and SRAM contents per build.
   bit         m_ram_en [2];
   int         m_b1     [2];
   int         m_b2     [2];
   bit         m_mode   [2];
   logic [7:0] exp_sram [2][32768];

   localparam int K_ROM = 0, K_RAM = 1, K_FLOAT = 2, K_NONE = 3;

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ram_en[d] = 1'b0; m_b1[d] = 0; m_b2[d] = 0; m_mode[d] = 1'b0;
      end
   endfunction

   function automatic int kind_of(input int d, input int a);
      if (a < 'h8000) return K_ROM;
      if (a >= 'hA000 && a < 'hC000) return (ramb_of(d) > 0 && m_ram_en[d]) ? K_RAM : K_FLOAT;
      return K_NONE;
   endfunction

   function automatic int exp_rom(input int d, input int a);
      int bank;
      if (a < 'h4000) bank = m_mode[d] ? m_b2[d] * 32 : 0;
      else            bank = m_b2[d] * 32 + ((m_b1[d] == 0) ? 1 : m_b1[d]);
      return (bank % rb_of(d)) * 16384 + (a % 16384);
   endfunction

   function automatic int exp_ram(input int d, input int a);
      int off;
      off = (m_mode[d] ? m_b2[d] * 8192 : 0) + (a - 'hA000);
      return off % (ramb_of(d) * 8192);
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic bus_read(input logic [15:0] a);
      int rom_n[2], ram_n[2], rom_at[2], ram_at[2], oe_at[2], k, ea;
      logic [20:0] ra[2];
      logic [14:0] sa[2];
      logic [7:0]  od[2];
      for (int d = 0; d < 2; d++) begin
         rom_n[d] = 0; ram_n[d] = 0; rom_at[d] = 0; ram_at[d] = 0; oe_at[d] = 0;
         ra[d] = '0; sa[d] = '0; od[d] = '0;
      end
      @(negedge pllClk);
      add  = a;
      cs_n = !(a >= 16'ha000 && a < 16'hc000);
      repeat (3) @(negedge pllClk);
      rd_n = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge pllClk); #1;
         for (int d = 0; d < 2; d++) begin
            if (rom_rd[d]) begin rom_n[d]++; rom_at[d] = cyc; ra[d] = rom_addr[d]; end
            if (ram_rd[d]) begin ram_n[d]++; ram_at[d] = cyc; sa[d] = ram_addr[d]; end
            if (data_oe[d] && oe_at[d] == 0) begin oe_at[d] = cyc; od[d] = data_out[d]; end
         end
      end
      @(negedge pllClk);
      rd_n = 1'b1;
      repeat (4) @(posedge pllClk); #1;
      for (int d = 0; d < 2; d++) begin
         chk("oe_release", d, 32'(data_oe[d]), 32'd0);
         chk("dout_release", d, 32'(data_out[d]), 32'hff);
         k = kind_of(d, int'(a));
         chk("rom_rd_count", d, rom_n[d], (k == K_ROM) ? 1 : 0);
         chk("ram_rd_count", d, ram_n[d], (k == K_RAM) ? 1 : 0);
         if (k == K_ROM) begin
            ea = exp_rom(d, int'(a));
            chk("rom_rd_cycle", d, rom_at[d], 2);
            chk("rom_addr", d, 32'(ra[d]), ea);
            chk("oe_rise_cycle", d, oe_at[d], lat_of(d) + 3);
            chk("rom_read_data", d, 32'(od[d]), 32'(rom_byte(21'(ea))));
         end else if (k == K_RAM) begin
            ea = exp_ram(d, int'(a));
            chk("ram_rd_cycle", d, ram_at[d], 2);
            chk("ram_addr", d, 32'(sa[d]), ea);
            chk("oe_rise_cycle", d, oe_at[d], lat_of(d) + 3);
            chk("ram_read_data", d, 32'(od[d]), 32'(exp_sram[d][ea]));
         end else if (k == K_FLOAT) begin
            chk("float_oe_cycle", d, oe_at[d], 3);
            chk("float_data", d, 32'(od[d]), 32'hff);
         end else begin
            chk("no_drive", d, oe_at[d], 0);
         end
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
      int we_n[2], ea;
      logic [14:0] wa[2];
      logic [7:0]  wd[2];
      bit hit;
      for (int d = 0; d < 2; d++) begin we_n[d] = 0; wa[d] = '0; wd[d] = '0; end
      @(negedge pllClk);
      add     = a;
      data_in = v;
      cs_n    = !(a >= 16'ha000 && a < 16'hc000);
      repeat (2) @(negedge pllClk);
      wr_n = 1'b0;
      repeat (4) @(negedge pllClk);
      wr_n = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(posedge pllClk); #1;
         for (int d = 0; d < 2; d++)
            if (ram_we[d]) begin we_n[d]++; wa[d] = ram_addr[d]; wd[d] = ram_wdata[d]; end
      end
      for (int d = 0; d < 2; d++) begin
         hit = (kind_of(d, int'(a)) == K_RAM);
         chk("ram_we_count", d, we_n[d], hit ? 1 : 0);
         if (hit) begin
            ea = exp_ram(d, int'(a));
            chk("ram_we_addr", d, 32'(wa[d]), ea);
            chk("ram_we_data", d, 32'(wd[d]), 32'(v));
            exp_sram[d][ea] = v;
         end
         if (a < 16'h2000)      m_ram_en[d] = (v[3:0] == 4'ha);
         else if (a < 16'h4000) m_b1[d] = int'(v[4:0]);
         else if (a < 16'h6000) m_b2[d] = int'(v[1:0]);
         else if (a < 16'h8000) m_mode[d] = v[0];
      end
   endtask

   task automatic check_reset_values();
      for (int d = 0; d < 2; d++) begin
         chk("rst_data_out", d, 32'(data_out[d]), 32'hff);
         chk("rst_data_oe", d, 32'(data_oe[d]), 32'd0);
         chk("rst_strobes", d, 32'({rom_rd[d], ram_rd[d], ram_we[d]}), 32'd0);
         chk("rst_rom_addr", d, 32'(rom_addr[d]), 32'd0);
         chk("rst_ram_addr", d, 32'(ram_addr[d]), 32'd0);
         chk("rst_ram_wdata", d, 32'(ram_wdata[d]), 32'd0);
      end
   endtask

   initial begin
      int seen_oe, seen_req, r;
      logic [15:0] ra;
      logic [7:0]  rv;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32768; i++) exp_sram[d][i] = sram_init(i);
      model_reset();
      reset_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; add = '0; data_in = '0;
      repeat (3) @(posedge pllClk); #1;
      check_reset_values();
      @(negedge pllClk);
      reset_n = 1'b1;

      // Power-up read through the default bank
      bus_read(16'h4000);
      // Bank 0 selects bank 1; bank 5 switches the upper window
      bus_write(16'h2000, 8'h00);
      bus_read(16'h4000);
      bus_write(16'h2000, 8'h05);
      bus_read(16'h4123);
      // RAM disabled floats, then enable and round-trip a byte
      bus_read(16'ha000);
      bus_write(16'h0000, 8'h0a);
      bus_write(16'ha010, 8'h5a);
      bus_read(16'ha010);
      // Mode 1 lifts bank2 into the low ROM window (masked differently per build)
      bus_write(16'h4000, 8'h02);
      bus_write(16'h6000, 8'h01);
      bus_read(16'h0100);
      bus_read(16'hb456);

      // Reset while a fetch is in flight: nothing may drive afterwards
      @(negedge pllClk);
      add = 16'h4000; cs_n = 1'b1;
      repeat (3) @(negedge pllClk);
      rd_n = 1'b0;
      repeat (3) @(negedge pllClk);
      reset_n = 1'b0;
      rd_n = 1'b1;
      repeat (2) @(negedge pllClk);
      reset_n = 1'b1;
      model_reset();
      seen_oe = 0; seen_req = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge pllClk); #1;
         for (int d = 0; d < 2; d++) begin
            if (data_oe[d]) seen_oe++;
            if (rom_rd[d] || ram_rd[d]) seen_req++;
         end
      end
      chk("reset_abort_oe", 0, seen_oe, 0);
      chk("reset_abort_req", 0, seen_req, 0);
      check_reset_values();
      bus_read(16'h4000);

      // Read and write strobed together: nothing issued, registers unchanged
      @(negedge pllClk);
      add = 16'h2000; data_in = 8'h07; cs_n = 1'b1;
      repeat (2) @(negedge pllClk);
      rd_n = 1'b0; wr_n = 1'b0;
      repeat (4) @(negedge pllClk);
      rd_n = 1'b1; wr_n = 1'b1;
      seen_req = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge pllClk); #1;
         for (int d = 0; d < 2; d++)
            if (rom_rd[d] || ram_rd[d] || ram_we[d] || data_oe[d]) seen_req++;
      end
      chk("clash_no_access", 0, seen_req, 0);
      bus_read(16'h4001);

      // Randomised mix of register writes, RAM writes and reads across the map
      for (int n = 0; n < 70; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            case ($urandom_range(0, 4))
               0:       ra = 16'($urandom_range(16'h0000, 16'h3fff));
               1:       ra = 16'($urandom_range(16'h4000, 16'h7fff));
               2, 3:    ra = 16'($urandom_range(16'ha000, 16'hbfff));
               default: ra = 16'($urandom_range(16'h8000, 16'hffff));
            endcase
            bus_read(ra);
         end else begin
            rv = 8'($urandom);
            case ($urandom_range(0, 5))
               0: begin
                  ra = 16'($urandom_range(16'h0000, 16'h1fff));
                  if ($urandom_range(0, 2) != 0) rv = 8'h0a;
               end
               1:       ra = 16'($urandom_range(16'h2000, 16'h3fff));
               2:       ra = 16'($urandom_range(16'h4000, 16'h5fff));
               3:       ra = 16'($urandom_range(16'h6000, 16'h7fff));
               default: ra = 16'($urandom_range(16'ha000, 16'hbfff));
            endcase
            bus_write(ra, rv);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
